// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 4-channel TDM demultiplexer.
package tdm_pkg;
   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   localparam logic [SEL_W-1:0] SLOT0     = '0;
   localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit slot counter: clear has priority over load-to-1, which has priority over increment.
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load1,
   input  logic             inc,
   output logic [SEL_W-1:0] sel
);

   logic [SEL_W-1:0] sel_q, sel_d;

   always_comb begin
      sel_d = sel_q;
      if (clr)
         sel_d = SLOT0;
      else if (load1)
         sel_d = SEL_W'(1);
      else if (inc)
         sel_d = sel_q + SEL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         sel_q <= SLOT0;
      else
         sel_q <= sel_d;
   end

   assign sel = sel_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: steers valid samples into registered channel
// outputs by slot, aligning on frame_sync and flagging alignment errors.
//
//   state  | meaning
//   HUNT   | waiting for a sample tagged with frame_sync; untagged samples dropped
//   LOCKED | aligned; sel tracks the next slot to be written
module tdm_demux_4ch
   import tdm_pkg::*;
#(
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     din,
   input  logic             din_valid,
   input  logic             frame_sync,
   input  logic             err_clr,
   output logic [W-1:0]     ch0,
   output logic [W-1:0]     ch1,
   output logic [W-1:0]     ch2,
   output logic [W-1:0]     ch3,
   output logic [NCH-1:0]   ch_valid,
   output logic             frame_done,
   output logic [SEL_W-1:0] sel,
   output logic             locked,
   output logic             sync_err
);

   tdm_state_t       state_q, state_d;
   logic [W-1:0]     ch_q [NCH];
   logic [W-1:0]     ch_d [NCH];
   logic [NCH-1:0]   ch_valid_q, ch_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             sync_err_q, sync_err_d;
   logic             err_set;
   logic             cnt_clr, cnt_load1, cnt_inc;
   logic [SEL_W-1:0] sel_q;

   tdm_slot_counter u_slot_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .sel   (sel_q)
   );

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      ch_valid_d   = '0;
      frame_done_d = 1'b0;
      err_set      = 1'b0;
      cnt_clr      = 1'b0;
      cnt_load1    = 1'b0;
      cnt_inc      = 1'b0;

      if (din_valid) begin
         case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  ch_d[SLOT0]       = din;
                  ch_valid_d[SLOT0] = 1'b1;
                  cnt_load1         = 1'b1;
                  state_d           = LOCKED;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  // an early sync abandons the partial frame and restarts at slot 0
                  err_set           = (sel_q != SLOT0);
                  ch_d[SLOT0]       = din;
                  ch_valid_d[SLOT0] = 1'b1;
                  cnt_load1         = 1'b1;
               end else if (sel_q == SLOT0) begin
                  err_set = 1'b1;
                  cnt_clr = 1'b1;
                  state_d = HUNT;
               end else begin
                  ch_d[sel_q]       = din;
                  ch_valid_d[sel_q] = 1'b1;
                  cnt_inc           = 1'b1;
                  frame_done_d      = (sel_q == LAST_SLOT);
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (err_set)
         sync_err_d = 1'b1;
      else if (err_clr)
         sync_err_d = 1'b0;
      else
         sync_err_d = sync_err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         ch_valid_q   <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         for (int k = 0; k < NCH; k++)
            ch_q[k] <= '0;
      end else begin
         state_q      <= state_d;
         ch_valid_q   <= ch_valid_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         ch_q         <= ch_d;
      end
   end

   assign ch0        = ch_q[0];
   assign ch1        = ch_q[1];
   assign ch2        = ch_q[2];
   assign ch3        = ch_q[3];
   assign ch_valid   = ch_valid_q;
   assign frame_done = frame_done_q;
   assign sel        = sel_q;
   assign locked     = (state_q == LOCKED);
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: a slot-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tdm_demux_4ch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       frame_sync = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] ch0, ch1, ch2, ch3;
   logic [3:0] ch_valid;
   logic       frame_done;
   logic [1:0] sel;
   logic       locked;
   logic       sync_err;

   int n_cmp = 0;
   int n_bad = 0;
   int fd_cnt = 0;

   tdm_demux_4ch #(.W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .err_clr    (err_clr),
      .ch0        (ch0),
      .ch1        (ch1),
      .ch2        (ch2),
      .ch3        (ch3),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .sel        (sel),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks which slot is expected next and whether we are aligned.
   logic [7:0] m_ch [4];
   logic [3:0] m_valid;
   logic       m_fd;
   int         m_slot;
   logic       m_locked;
   logic       m_err;
   logic       m_started = 1'b0;

   always @(posedge clk) begin
      logic set_err;
      set_err = 1'b0;
      m_valid = '0;
      m_fd    = 1'b0;
      if (rst) begin
         for (int k = 0; k < 4; k++) m_ch[k] = '0;
         m_slot    = 0;
         m_locked  = 1'b0;
         m_err     = 1'b0;
         m_started = 1'b1;
      end else begin
         if (din_valid) begin
            if (frame_sync) begin
               if (m_locked && m_slot != 0) set_err = 1'b1;
               m_ch[0]    = din;
               m_valid[0] = 1'b1;
               m_slot     = 1;
               m_locked   = 1'b1;
            end else if (m_locked) begin
               if (m_slot == 0) begin
                  set_err  = 1'b1;
                  m_locked = 1'b0;
               end else begin
                  m_ch[m_slot]    = din;
                  m_valid[m_slot] = 1'b1;
                  m_fd            = (m_slot == 3);
                  m_slot          = (m_slot + 1) % 4;
               end
            end
         end
         if (set_err) m_err = 1'b1;
         else if (err_clr) m_err = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("ch0", 32'(ch0), 32'(m_ch[0]));
         chk("ch1", 32'(ch1), 32'(m_ch[1]));
         chk("ch2", 32'(ch2), 32'(m_ch[2]));
         chk("ch3", 32'(ch3), 32'(m_ch[3]));
         chk("ch_valid", 32'(ch_valid), 32'(m_valid));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
         chk("sel", 32'(sel), 32'(m_slot));
         chk("locked", 32'(locked), 32'(m_locked));
         chk("sync_err", 32'(sync_err), 32'(m_err));
         if (frame_done === 1'b1) fd_cnt++;
      end
   end

   task automatic cyc(input logic v, input logic s, input logic [7:0] d,
                      input logic c = 1'b0, input logic r = 1'b0);
      din_valid  = v;
      frame_sync = s;
      din        = d;
      err_clr    = c;
      rst        = r;
      @(posedge clk);
      #2;
   endtask

   task automatic send_frame(input logic [7:0] a, b, c, d);
      cyc(1, 1, a);
      cyc(1, 0, b);
      cyc(1, 0, c);
      cyc(1, 0, d);
   endtask

   initial begin
      cyc(0, 0, 8'h00, 0, 1);
      cyc(0, 0, 8'h00, 0, 1);
      chk("rst_ch0", 32'(ch0), 0);
      chk("rst_ch3", 32'(ch3), 0);
      chk("rst_ch_valid", 32'(ch_valid), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_sync_err", 32'(sync_err), 0);

      // aligned frame
      fd_cnt = 0;
      cyc(1, 1, 8'h11);
      chk("t1_v0", 32'(ch_valid), 32'b0001);
      cyc(1, 0, 8'h22);
      chk("t1_v1", 32'(ch_valid), 32'b0010);
      cyc(1, 0, 8'h33);
      chk("t1_v2", 32'(ch_valid), 32'b0100);
      cyc(1, 0, 8'h44);
      chk("t1_v3", 32'(ch_valid), 32'b1000);
      chk("t1_fd", 32'(frame_done), 1);
      chk("t1_ch", {ch3, ch2, ch1, ch0}, 32'h44332211);
      chk("t1_sel", 32'(sel), 0);
      chk("t1_locked", 32'(locked), 1);
      cyc(0, 0, 8'h00);
      chk("t1_fd_cnt", fd_cnt, 1);

      // HUNT discards untagged samples
      cyc(0, 0, 8'h00, 0, 1);
      fd_cnt = 0;
      cyc(1, 0, 8'hAA);
      cyc(1, 0, 8'hBB);
      chk("t2_hunt_locked", 32'(locked), 0);
      send_frame(8'h01, 8'h02, 8'h03, 8'h04);
      cyc(0, 0, 8'h00);
      chk("t2_ch", {ch3, ch2, ch1, ch0}, 32'h04030201);
      chk("t2_fd_cnt", fd_cnt, 1);

      // gaps between valid samples
      cyc(0, 0, 8'h00, 0, 1);
      fd_cnt = 0;
      cyc(1, 1, 8'h11); cyc(0, 0, 8'h99);
      cyc(1, 0, 8'h22); cyc(0, 0, 8'h99);
      chk("t3_sel_gap", 32'(sel), 2);
      chk("t3_v_gap", 32'(ch_valid), 0);
      cyc(1, 0, 8'h33); cyc(0, 0, 8'h99);
      cyc(1, 0, 8'h44); cyc(0, 0, 8'h99);
      chk("t3_ch", {ch3, ch2, ch1, ch0}, 32'h44332211);
      chk("t3_fd_cnt", fd_cnt, 1);

      // early sync
      cyc(0, 0, 8'h00, 0, 1);
      fd_cnt = 0;
      cyc(1, 1, 8'h10);
      cyc(1, 0, 8'h20);
      cyc(1, 1, 8'h30);
      chk("t4_err", 32'(sync_err), 1);
      chk("t4_ch0", 32'(ch0), 32'h30);
      chk("t4_sel", 32'(sel), 1);
      cyc(0, 0, 8'h00);
      chk("t4_no_fd", fd_cnt, 0);
      cyc(1, 0, 8'h40);
      cyc(1, 0, 8'h50);
      cyc(1, 0, 8'h60);
      cyc(0, 0, 8'h00);
      chk("t4_fd_cnt", fd_cnt, 1);
      chk("t4_ch3", 32'(ch3), 32'h60);

      // missing sync and err_clr behaviour
      cyc(0, 0, 8'h00, 1);
      chk("t5_clr", 32'(sync_err), 0);
      cyc(1, 0, 8'h77);
      chk("t5_err", 32'(sync_err), 1);
      chk("t5_locked", 32'(locked), 0);
      cyc(0, 0, 8'h00);
      chk("t5_ch", {ch3, ch2, ch1, ch0}, 32'h60504030);
      cyc(0, 0, 8'h00, 1);
      chk("t5_clr2", 32'(sync_err), 0);
      send_frame(8'h81, 8'h82, 8'h83, 8'h84);
      cyc(1, 0, 8'h88, 1);
      chk("t5_set_wins", 32'(sync_err), 1);
      chk("t5_ch0_hold", 32'(ch0), 32'h81);

      // reset mid-frame
      cyc(0, 0, 8'h00, 0, 1);
      cyc(1, 1, 8'hA1);
      cyc(1, 0, 8'hA2);
      cyc(1, 0, 8'hA3, 0, 1);
      chk("t6_ch", {ch3, ch2, ch1, ch0}, 0);
      chk("t6_locked", 32'(locked), 0);
      chk("t6_sel", 32'(sel), 0);
      fd_cnt = 0;
      send_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);
      cyc(0, 0, 8'h00);
      chk("t6_ch_after", {ch3, ch2, ch1, ch0}, 32'hB4B3B2B1);
      chk("t6_fd_cnt", fd_cnt, 1);

      cyc(0, 0, 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Four-channel time-division demultiplexer; the receive-side counterpart of the team's 4:1 mux.
- Accepts a single serialised sample stream in which slot 0 is tagged by frame_sync.
- Steers each valid sample into one of four registered channel outputs using an internal 2-bit slot counter, which plays the role of the mux's s1/s0 select.
- Sits after a TDM link or serial front end; feeds per-channel consumers.

Parameters:
- W, 8, data width of din and of each channel output.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  W  incoming serial sample.
- din_valid  input  1  din holds a sample this cycle.
- frame_sync  input  1  qualifies the current sample as slot 0; ignored when din_valid=0.
- err_clr  input  1  clears sync_err.
- ch0, ch1, ch2, ch3  output  W each  last sample captured for that slot; registered.
- ch_valid  output  4  bit k pulses for one cycle when chk is updated.
- frame_done  output  1  one-cycle pulse when ch3 completes an aligned frame (slots 0..3 in order).
- sel  output  2  next slot to be written (the demux select).
- locked  output  1  high in LOCKED state.
- sync_err  output  1  sticky alignment-error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - ch0..ch3=0, ch_valid=0, frame_done=0, sel=0, locked=0, sync_err=0, state=HUNT.
  - Reset overrides all other inputs, including mid-frame; a partial frame is discarded.
- Latency: a sample accepted at edge N appears on chk, with ch_valid[k]=1, after edge N, i.e. 1 cycle. Pulses last exactly one cycle.
- Cycles with din_valid=0: no state change, no pulses, outputs hold.
- HUNT state:
  - Valid sample with frame_sync=0: discarded.
  - Valid sample with frame_sync=1: write ch0, ch_valid[0] pulse, sel<=1, go to LOCKED.
- LOCKED state, on a valid sample:
  - frame_sync=1, sel=0: write ch0, sel<=1 (normal).
  - frame_sync=0, sel in 1..3: write ch[sel], sel<=sel+1 (wraps 3->0).
  - Writing ch3 pulses frame_done together with ch_valid[3], but only if the frame started with an aligned sync (no realign inside the frame).
  - frame_sync=1, sel!=0 (early sync): set sync_err; the sample is treated as a new slot 0 (write ch0, sel<=1). The partial frame is abandoned and no frame_done is issued for it.
  - frame_sync=0, sel=0 (missing sync): set sync_err; discard the sample, sel stays 0, go to HUNT.
- sync_err:
  - Set by either error above. Cleared by err_clr=1.
  - If a set event and err_clr occur in the same cycle, set wins.
- Channel registers not written in a cycle hold their value; they never clear except on reset.
- Width: sel is 2-bit modulo-4; no other arithmetic.

Decomposition:
- Package tdm_pkg holds:
  - NCH=4, SEL_W=2.
  - State enum {HUNT, LOCKED}.
  - A localparam for the slot-0 index.
- Optional sub-module tdm_slot_counter (2-bit counter with load-to-1, hold, clear). Everything else stays in tdm_demux_4ch.

Test Plan:
- Reset then aligned frame: din=0x11,0x22,0x33,0x44 valid back-to-back, sync on 0x11 -> ch0..3=0x11/0x22/0x33/0x44; ch_valid 0001,0010,0100,1000 on consecutive cycles; frame_done with the last; sel ends 0; locked=1.
- HUNT discard: 0xAA, 0xBB without sync, then a sync frame 0x01..0x04 -> 0xAA/0xBB never appear on any channel; frame_done once.
- Gaps: the same frame with din_valid=0 on alternate cycles -> identical channel values; pulses only on valid cycles; sel holds during gaps.
- Early sync: sync on 0x10, then 0x20, then sync on 0x30 -> sync_err=1; ch0=0x30; no frame_done; sel=1. Then 0x40,0x50,0x60 -> frame_done, ch3=0x60.
- Missing sync: after a complete frame, send 0x77 without sync -> sync_err=1, locked=0, 0x77 discarded. A subsequent err_clr pulse clears sync_err; err_clr asserted together with a new error leaves sync_err=1.
- Reset mid-frame: rst after slots 0 and 1 are written -> all outputs 0, HUNT. The next sync frame completes normally.
